// File: rtl/vga_seq_pkg.sv
// Shared types and helpers for the VGA screen sequencer: FSM states, fade level range
// and the per-channel colour scaler.
package vga_seq_pkg;

  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } seqState_e;

  localparam int LEVEL_W = 5;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 5'd16;

  // Colour is handled as NUM_LANES channels (R, G, B) of VEC_W bits each.
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 4;

  // (c * level) >> 4; level 16 is an exact pass-through, level 0 is black.
  function automatic logic [VEC_W-1:0] scaleColour(input logic [VEC_W-1:0]   c,
                                                   input logic [LEVEL_W-1:0] lvl);
    logic [2*VEC_W-1:0] prod;
    prod = (2*VEC_W)'(c) * (2*VEC_W)'(lvl);
    return prod[2*VEC_W-1:VEC_W];
  endfunction

endpackage

// File: rtl/vga_frame_edge.sv
// Two-flop synchroniser for an asynchronous level plus a falling-edge detect on the
// synchronised value. The history flop resets to the same value so reset never fakes an edge.
module vga_frame_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iD,
  output logic oSync,
  output logic oFall
);

  logic meta;
  logic hist;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      meta  <= RESET_VAL;
      oSync <= RESET_VAL;
      hist  <= RESET_VAL;
    end else begin
      meta  <= iD;
      oSync <= meta;
      hist  <= oSync;
    end
  end

  assign oFall = hist & ~oSync;

endmodule

// File: rtl/vga_screen_sequencer.sv
// Selects between game pattern and splash image for the VGA DAC, switching only at frame
// boundaries with a frame-stepped fade, a debounced select switch and a game frame tick.
module vga_screen_sequencer
  import vga_seq_pkg::*;
#(
  parameter int   FRAMES_PER_STEP = 2,
  parameter int   STABLE_FRAMES   = 3,
  parameter logic RESET_SEL       = 1'b1
) (
  input  logic       iVGA_CLK,
  input  logic       iRST,
  input  logic       iVGA_VS,
  input  logic       iSW,
  input  logic [3:0] iPat_R,
  input  logic [3:0] iPat_G,
  input  logic [3:0] iPat_B,
  input  logic [3:0] iImg_R,
  input  logic [3:0] iImg_G,
  input  logic [3:0] iImg_B,
  output logic [3:0] oRed,
  output logic [3:0] oGreen,
  output logic [3:0] oBlue,
  output logic       oSel,
  output logic       oBusy,
  output logic       oFrame_tick
);

  localparam int STABLE_W = $clog2(STABLE_FRAMES + 1);
  localparam int STEP_W   = $clog2(FRAMES_PER_STEP + 1);

  logic                fp;
  logic                vsSync;
  logic                swSync;
  logic                swCand;
  logic                swAccepted;
  logic [STABLE_W-1:0] stableCnt;
  logic [STEP_W-1:0]   stepCnt;
  logic                stepHit;
  seqState_e           state;
  logic [LEVEL_W-1:0]  level;

  logic [NUM_LANES-1:0][VEC_W-1:0] pat;
  logic [NUM_LANES-1:0][VEC_W-1:0] img;
  logic [NUM_LANES-1:0][VEC_W-1:0] scaled;
  logic [NUM_LANES-1:0][VEC_W-1:0] colour;

  vga_frame_edge #(.RESET_VAL(1'b1)) uVsEdge (
    .iClk  (iVGA_CLK),
    .iRst  (iRST),
    .iD    (iVGA_VS),
    .oSync (vsSync),
    .oFall (fp)
  );

  vga_frame_edge #(.RESET_VAL(RESET_SEL)) uSwSync (
    .iClk  (iVGA_CLK),
    .iRst  (iRST),
    .iD    (iSW),
    .oSync (swSync),
    .oFall ()
  );

  // Debounce: the switch must read the same value on STABLE_FRAMES frame pulses in a row.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      swCand     <= RESET_SEL;
      stableCnt  <= '0;
      swAccepted <= RESET_SEL;
    end else if (fp) begin
      if (swSync == swCand) begin
        if (stableCnt != STABLE_W'(STABLE_FRAMES)) begin
          stableCnt <= stableCnt + 1'b1;
          if (stableCnt + 1'b1 == STABLE_W'(STABLE_FRAMES))
            swAccepted <= swCand;
        end
      end else begin
        swCand    <= swSync;
        stableCnt <= STABLE_W'(1);
        if (STABLE_FRAMES == 1)
          swAccepted <= swSync;
      end
    end
  end

  assign stepHit = (stepCnt == STEP_W'(FRAMES_PER_STEP - 1));

  // All sequencing moves only on fp, so sel/level never change mid-frame.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      state       <= SHOW;
      level       <= LEVEL_MAX;
      oSel        <= RESET_SEL;
      stepCnt     <= '0;
      oBusy       <= 1'b0;
      oFrame_tick <= 1'b0;
    end else begin
      oFrame_tick <= fp && (state == SHOW) && !oSel;
      if (fp) begin
        case (state)
          SHOW: begin
            level <= LEVEL_MAX;
            if (swAccepted != oSel) begin
              state   <= FADE_OUT;
              oBusy   <= 1'b1;
              stepCnt <= '0;
            end
          end
          FADE_OUT: begin
            if (swAccepted == oSel) begin
              // Request withdrawn: climb back from wherever the fade got to.
              state   <= FADE_IN;
              stepCnt <= '0;
            end else begin
              stepCnt <= stepHit ? '0 : stepCnt + 1'b1;
              if (stepHit) begin
                if (level == '0) begin
                  oSel    <= ~oSel;
                  state   <= FADE_IN;
                  stepCnt <= '0;
                end else begin
                  level <= level - 1'b1;
                end
              end
            end
          end
          FADE_IN: begin
            stepCnt <= stepHit ? '0 : stepCnt + 1'b1;
            if (stepHit) begin
              // A withdrawal before any fade-out step lands here already at full level.
              if (level >= LEVEL_MAX - 1'b1) begin
                level   <= LEVEL_MAX;
                state   <= SHOW;
                oBusy   <= 1'b0;
                stepCnt <= '0;
              end else begin
                level <= level + 1'b1;
              end
            end
          end
          default: begin
            state   <= SHOW;
            level   <= LEVEL_MAX;
            oBusy   <= 1'b0;
            stepCnt <= '0;
          end
        endcase
      end
    end
  end

  assign pat = {iPat_R, iPat_G, iPat_B};
  assign img = {iImg_R, iImg_G, iImg_B};

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    assign scaled[g] = scaleColour(oSel ? img[g] : pat[g], level);
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) colour <= '0;
    else      colour <= scaled;
  end

  assign oRed   = colour[2];
  assign oGreen = colour[1];
  assign oBlue  = colour[0];

endmodule

// File: tb/tb_vga_screen_sequencer.sv
// Directed bench for vga_screen_sequencer: stimulus pushes hand-computed expectations
// stamped with a cycle number, and a negedge monitor pops and compares them.
module tb_vga_screen_sequencer;

  logic       clk = 1'b0;
  logic       iRST, iVGA_VS, iSW;
  logic [3:0] iPat_R, iPat_G, iPat_B, iImg_R, iImg_G, iImg_B;
  logic [3:0] oRed, oGreen, oBlue;
  logic       oSel, oBusy, oFrame_tick;

  vga_screen_sequencer #(
    .FRAMES_PER_STEP (1),
    .STABLE_FRAMES   (2),
    .RESET_SEL       (1'b1)
  ) dut (
    .iVGA_CLK    (clk),
    .iRST        (iRST),
    .iVGA_VS     (iVGA_VS),
    .iSW         (iSW),
    .iPat_R      (iPat_R),
    .iPat_G      (iPat_G),
    .iPat_B      (iPat_B),
    .iImg_R      (iImg_R),
    .iImg_G      (iImg_G),
    .iImg_B      (iImg_B),
    .oRed        (oRed),
    .oGreen      (oGreen),
    .oBlue       (oBlue),
    .oSel        (oSel),
    .oBusy       (oBusy),
    .oFrame_tick (oFrame_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    bit          tickOnly;
    logic [3:0]  r, g, b;
    logic        sel, busy, tick;
    logic [95:0] nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   compared   = 0;
  int   mismatched = 0;

  // Monitor: compare every expectation whose stamp has been reached.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      compared++;
      if (e.tickOnly) begin
        if (oFrame_tick !== e.tick) begin
          mismatched++;
          $display("FAIL %0s cyc=%0d: tick got %b want %b", e.nm, cyc, oFrame_tick, e.tick);
        end
      end else if ({oRed, oGreen, oBlue, oSel, oBusy, oFrame_tick} !==
                   {e.r, e.g, e.b, e.sel, e.busy, e.tick}) begin
        mismatched++;
        $display("FAIL %0s cyc=%0d: got rgb=%h%h%h sel=%b busy=%b tick=%b want rgb=%h%h%h sel=%b busy=%b tick=%b",
                 e.nm, cyc, oRed, oGreen, oBlue, oSel, oBusy, oFrame_tick,
                 e.r, e.g, e.b, e.sel, e.busy, e.tick);
      end
    end
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int at, input bit tickOnly, input logic [3:0] r, input logic [3:0] g,
                      input logic [3:0] b, input logic sel, input logic busy, input logic tick,
                      input logic [95:0] nm);
    exp_t x;
    x.at = at; x.tickOnly = tickOnly; x.r = r; x.g = g; x.b = b;
    x.sel = sel; x.busy = busy; x.tick = tick; x.nm = nm;
    q.push_back(x);
  endtask

  // Expect settled outputs in the current cycle (grey level: all channels equal).
  task automatic expectOut(input logic [95:0] nm, input logic [3:0] v, input logic sel,
                           input logic busy);
    push(cyc, 1'b0, v, v, v, sel, busy, 1'b0, nm);
  endtask

  // One 10-cycle frame: VS low for 5, high for 5. The tick, if any, must land exactly
  // on the third clock after the raw falling edge and nowhere else in the frame.
  task automatic frame(input logic expTick);
    int n0;
    n0 = cyc;
    iVGA_VS = 1'b0;
    for (int k = 1; k < 10; k++)
      push(n0 + k, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, expTick && (k == 3), "frame_tick");
    repeat (5) clk1();
    iVGA_VS = 1'b1;
    repeat (5) clk1();
  endtask

  task automatic frames(input int n, input logic expTick);
    for (int i = 0; i < n; i++) frame(expTick);
  endtask

  initial begin
    iRST = 1'b1; iVGA_VS = 1'b1; iSW = 1'b1;
    iImg_R = 4'hF; iImg_G = 4'hF; iImg_B = 4'hF;
    iPat_R = 4'h3; iPat_G = 4'h3; iPat_B = 4'h3;
    repeat (3) clk1();

    // 1: reset state, then image passes through one clock later
    expectOut("reset", 4'h0, 1'b1, 1'b0);
    iRST = 1'b0;
    clk1();
    expectOut("img_pass", 4'hF, 1'b1, 1'b0);
    frames(3, 1'b0);
    expectOut("img_show", 4'hF, 1'b1, 1'b0);

    // 3: single-frame glitch on the switch is rejected
    iSW = 1'b0; frame(1'b0);
    expectOut("glitch_a", 4'hF, 1'b1, 1'b0);
    iSW = 1'b1; frames(2, 1'b0);
    expectOut("glitch_b", 4'hF, 1'b1, 1'b0);

    // 4: request withdrawn at level 10
    iSW = 1'b0;
    frames(3, 1'b0);
    expectOut("wd_start", 4'hF, 1'b1, 1'b1);
    frames(4, 1'b0);
    iSW = 1'b1;
    frames(2, 1'b0);
    expectOut("wd_lvl10", 4'h9, 1'b1, 1'b1);
    frame(1'b0);
    expectOut("wd_fadein", 4'h9, 1'b1, 1'b1);
    frames(5, 1'b0);
    expectOut("wd_lvl15", 4'hE, 1'b1, 1'b1);
    frame(1'b0);
    expectOut("wd_done", 4'hF, 1'b1, 1'b0);

    // 2: full image -> game transition
    iSW = 1'b0;
    frames(2, 1'b0);
    expectOut("sw_pending", 4'hF, 1'b1, 1'b0);
    frame(1'b0);
    expectOut("fo_start", 4'hF, 1'b1, 1'b1);
    frames(8, 1'b0);
    expectOut("fo_lvl8", 4'h7, 1'b1, 1'b1);
    frames(8, 1'b0);
    expectOut("fo_lvl0", 4'h0, 1'b1, 1'b1);
    frame(1'b0);
    expectOut("toggle", 4'h0, 1'b0, 1'b1);
    frames(6, 1'b0);
    expectOut("fi_lvl6", 4'h1, 1'b0, 1'b1);
    frames(9, 1'b0);
    expectOut("fi_lvl15", 4'h2, 1'b0, 1'b1);
    frame(1'b0);
    expectOut("game_show", 4'h3, 1'b0, 1'b0);

    // 5: one tick per frame in game SHOW
    frames(3, 1'b1);
    expectOut("game_ticks", 4'h3, 1'b0, 1'b0);

    // 6: game -> image request, withdrawn to get a FADE_IN with sel=0, then reset
    iSW = 1'b1;
    frames(2, 1'b1);
    iSW = 1'b0;
    frame(1'b1);
    expectOut("g_fo_start", 4'h3, 1'b0, 1'b1);
    frame(1'b0);
    expectOut("g_fo_lvl15", 4'h2, 1'b0, 1'b1);
    frame(1'b0);
    expectOut("g_fadein", 4'h2, 1'b0, 1'b1);
    iSW = 1'b1;
    iRST = 1'b1;
    clk1();
    expectOut("rst_mid", 4'h0, 1'b1, 1'b0);
    iRST = 1'b0;
    clk1();
    expectOut("rst_img", 4'hF, 1'b1, 1'b0);
    frames(2, 1'b0);
    expectOut("rst_settle", 4'hF, 1'b1, 1'b0);

    repeat (3) clk1();
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
